// File: rtl/keccak_result_checker_pkg.sv
// Shared widths and helpers for the keccak result checker.
// Optional digest capture in the result FIFO is enabled by KECCAK_HASH_CAPTURE_EN.
package keccak_result_checker_pkg;

    localparam int HASH_W      = 256;
    localparam int NONCE_W_DEF = 32;
    localparam int DROP_W      = 16;
    localparam int CNT_W       = 32;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // Digest is an unsigned 256-bit number, MSB first; a hit is digest <= target.
    function automatic logic is_hit(input logic [HASH_W-1:0] digest,
                                    input logic [HASH_W-1:0] target);
        return digest <= target;
    endfunction

endpackage

// File: rtl/keccak_result_checker_if.sv
// Hasher-output and result-handshake bundle for the keccak result checker.
// result_hash exists only when KECCAK_HASH_CAPTURE_EN is defined.
interface keccak_result_checker_if
    import keccak_result_checker_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF
) ();
    // Handshake: a head entry transfers on a rising clk where result_valid && result_ready;
    // result_nonce/result_hash hold steady while result_valid && !result_ready.
    logic               hash_valid;
    logic [HASH_W-1:0]  hash_in;
    logic               result_valid;
    logic               result_ready;
    logic [NONCE_W-1:0] result_nonce;
`ifdef KECCAK_HASH_CAPTURE_EN
    logic [HASH_W-1:0]  result_hash;

    modport master (output hash_valid, hash_in, result_ready,
                    input  result_valid, result_nonce, result_hash);
    modport slave  (input  hash_valid, hash_in, result_ready,
                    output result_valid, result_nonce, result_hash);
`else
    modport master (output hash_valid, hash_in, result_ready,
                    input  result_valid, result_nonce);
    modport slave  (input  hash_valid, hash_in, result_ready,
                    output result_valid, result_nonce);
`endif
endinterface

// File: rtl/keccak_result_fifo.sv
// Synchronous FIFO with async reset and flush; push and pop on a full FIFO both succeed.
module keccak_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keccak_result_checker.sv
// Tags in-order hasher digests with nonces, compares against target and queues winners.
// KECCAK_HASH_CAPTURE_EN: FIFO entries also carry the digest, presented on result_hash.
module keccak_result_checker
    import keccak_result_checker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NONCE_W    = NONCE_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NONCE_W-1:0]      base_nonce,
    input  logic [HASH_W-1:0]       target,
    keccak_result_checker_if.slave  hif,
    output logic [CNT_W-1:0]        hash_count,
    output logic [DROP_W-1:0]       dropped
);
`ifdef KECCAK_HASH_CAPTURE_EN
    localparam int ENTRY_W = NONCE_W + HASH_W;
`else
    localparam int ENTRY_W = NONCE_W;
`endif

    logic [NONCE_W-1:0] exp_nonce_q, exp_nonce_d;
    logic [CNT_W-1:0]   hash_count_q, hash_count_d;
    logic [DROP_W-1:0]  dropped_q, dropped_d;
    logic               s1_valid_q, s1_valid_d;
    logic [NONCE_W-1:0] s1_nonce_q, s1_nonce_d;
    logic [HASH_W-1:0]  s1_hash_q, s1_hash_d;

    logic               hit, push, pop, drop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

    // A start in the same cycle as a compare hit flushes rather than pushes.
    assign hit  = s1_valid_q && is_hit(s1_hash_q, target);
    assign push = hit && !start;
    assign pop  = !fifo_empty && hif.result_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        exp_nonce_d  = exp_nonce_q;
        hash_count_d = hash_count_q;
        dropped_d    = dropped_q;
        s1_valid_d   = 1'b0;
        s1_nonce_d   = s1_nonce_q;
        s1_hash_d    = s1_hash_q;
        if (start) begin
            exp_nonce_d  = base_nonce;
            hash_count_d = '0;
            dropped_d    = '0;
        end else begin
            if (hif.hash_valid) begin
                s1_valid_d   = 1'b1;
                s1_nonce_d   = exp_nonce_q;
                s1_hash_d    = hif.hash_in;
                exp_nonce_d  = exp_nonce_q + NONCE_W'(1);
                hash_count_d = hash_count_q + CNT_W'(1);
            end
            if (drop) begin
                dropped_d = sat_inc(dropped_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_nonce_q  <= '0;
            hash_count_q <= '0;
            dropped_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_nonce_q   <= '0;
            s1_hash_q    <= '0;
        end else begin
            exp_nonce_q  <= exp_nonce_d;
            hash_count_q <= hash_count_d;
            dropped_q    <= dropped_d;
            s1_valid_q   <= s1_valid_d;
            s1_nonce_q   <= s1_nonce_d;
            s1_hash_q    <= s1_hash_d;
        end
    end

`ifdef KECCAK_HASH_CAPTURE_EN
    assign fifo_wdata       = {s1_nonce_q, s1_hash_q};
    assign hif.result_nonce = fifo_rdata[ENTRY_W-1 -: NONCE_W];
    assign hif.result_hash  = fifo_rdata[HASH_W-1:0];
`else
    assign fifo_wdata       = s1_nonce_q;
    assign hif.result_nonce = fifo_rdata;
`endif

    keccak_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hif.result_valid = !fifo_empty;
    assign hash_count       = hash_count_q;
    assign dropped          = dropped_q;

endmodule

// File: tb/tb_keccak_result_checker.sv
// Scoreboard bench for keccak_result_checker; result_hash is checked when
// KECCAK_HASH_CAPTURE_EN is defined.
module tb_keccak_result_checker;
    import keccak_result_checker_pkg::*;

    localparam int NW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NW-1:0]     base_nonce;
    logic [HASH_W-1:0] target;
    logic [CNT_W-1:0]  hash_count;
    logic [DROP_W-1:0] dropped;

    int checks = 0;
    int errors = 0;

    logic [NW-1:0]     exp_q[$];
    logic [HASH_W-1:0] exp_h_q[$];
    logic [NW-1:0]     model_nonce;

    keccak_result_checker_if #(.NONCE_W(NW)) hif ();

    keccak_result_checker #(
        .FIFO_DEPTH (DEPTH),
        .NONCE_W    (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_nonce (base_nonce),
        .target     (target),
        .hif        (hif.slave),
        .hash_count (hash_count),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [HASH_W-1:0] rand_hash();
        logic [HASH_W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: scoreboard sample at negedge, then return just after posedge.
    task automatic tick();
        logic [NW-1:0]     e;
        logic [HASH_W-1:0] eh;
        @(negedge clk);
        if (!reset && hif.result_valid && hif.result_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%h required=none", hif.result_nonce);
            end else begin
                e  = exp_q.pop_front();
                eh = exp_h_q.pop_front();
                if (hif.result_nonce !== e) begin
                    errors++;
                    $display("FAIL result_nonce got=%h required=%h", hif.result_nonce, e);
                end
`ifdef KECCAK_HASH_CAPTURE_EN
                checks++;
                if (hif.result_hash !== eh) begin
                    errors++;
                    $display("FAIL result_hash got=%h required=%h", hif.result_hash, eh);
                end
`else
                eh = '0;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hif.hash_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [NW-1:0] b);
        start      = 1'b1;
        base_nonce = b;
        tick();
        start = 1'b0;
        exp_q.delete();
        exp_h_q.delete();
        model_nonce = b;
    endtask

    // record=0 marks a digest whose hit is expected to be dropped.
    task automatic drive(input logic [HASH_W-1:0] h, input bit record);
        hif.hash_valid = 1'b1;
        hif.hash_in    = h;
        if (record && (h <= target)) begin
            exp_q.push_back(model_nonce);
            exp_h_q.push_back(h);
        end
        model_nonce = model_nonce + 1;
        tick();
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        hif.hash_valid = 1'b0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
            exp_q.delete();
            exp_h_q.delete();
        end
        checks++;
        if (hif.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid got=%b required=0", hif.result_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base_nonce = '0;
        target = '0;
        hif.hash_valid = 1'b0;
        hif.hash_in = '0;
        hif.result_ready = 1'b0;
        model_nonce = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (hif.result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required=0", hif.result_valid); end
        if (hif.result_nonce !== '0) begin errors++; $display("FAIL rst_nonce got=%h required=0", hif.result_nonce); end
        if (hash_count !== '0) begin errors++; $display("FAIL rst_count got=%0d required=0", hash_count); end
        if (dropped !== '0) begin errors++; $display("FAIL rst_dropped got=%0d required=0", dropped); end
`ifdef KECCAK_HASH_CAPTURE_EN
        checks++;
        if (hif.result_hash !== '0) begin errors++; $display("FAIL rst_hash got=%h required=0", hif.result_hash); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        hif.result_ready = 1'b1;
        target = '1;
        do_start(32'd100);
        drive(rand_hash(), 1'b1);
        checks++;
        if (hif.result_valid !== 1'b0) begin errors++; $display("FAIL latency_n1 got=%b required=0", hif.result_valid); end
        drive(rand_hash(), 1'b1);
        checks++;
        if (hif.result_valid !== 1'b1) begin errors++; $display("FAIL latency_n2 got=%b required=1", hif.result_valid); end
        drive(rand_hash(), 1'b1);
        wait_drain(20);
        checks++;
        if (hash_count !== 32'd3) begin errors++; $display("FAIL basic_count got=%0d required=3", hash_count); end
    endtask

    task automatic test_compare();
        logic [HASH_W-1:0] h;
        hif.result_ready = 1'b1;
        target = {32'h0000_00FF, {224{1'b1}}};
        do_start(32'd500);
        drive({32'h0000_0100, 224'h0}, 1'b1);
        drive({32'h0000_00FF, {224{1'b1}}}, 1'b1);
        checks++;
        if (hash_count !== 32'd2) begin errors++; $display("FAIL cmp_count got=%0d required=2", hash_count); end
        for (int i = 0; i < 8; i++) begin
            h = rand_hash();
            h[255:224] = $urandom_range(0, 511);
            drive(h, 1'b1);
        end
        wait_drain(30);
        checks++;
        if (hash_count !== 32'd10) begin errors++; $display("FAIL cmp_count_end got=%0d required=10", hash_count); end
    endtask

    task automatic test_full();
        hif.result_ready = 1'b0;
        target = '1;
        do_start(32'd1000);
        for (int i = 0; i < 6; i++) drive(rand_hash(), i < DEPTH);
        idle(3);
        checks += 2;
        if (dropped !== 16'd2) begin errors++; $display("FAIL full_dropped got=%0d required=2", dropped); end
        if (hif.result_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b required=1", hif.result_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hif.result_nonce !== exp_q[0]) begin
                errors++;
                $display("FAIL stall_nonce got=%h required=%h", hif.result_nonce, exp_q[0]);
            end
            tick();
        end
        hif.result_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (dropped !== 16'd2) begin errors++; $display("FAIL full_dropped_end got=%0d required=2", dropped); end
    endtask

    task automatic test_full_push_pop();
        hif.result_ready = 1'b0;
        target = '1;
        do_start(32'd1200);
        for (int i = 0; i < DEPTH; i++) drive(rand_hash(), 1'b1);
        idle(3);
        drive(rand_hash(), 1'b1);
        hif.hash_valid   = 1'b0;
        hif.result_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (dropped !== 16'd0) begin errors++; $display("FAIL pushpop_dropped got=%0d required=0", dropped); end
    endtask

    task automatic test_wrap();
        hif.result_ready = 1'b1;
        target = '1;
        do_start(32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) drive(rand_hash(), 1'b1);
        wait_drain(20);
        checks++;
        if (hash_count !== 32'd3) begin errors++; $display("FAIL wrap_count got=%0d required=3", hash_count); end
    endtask

    task automatic test_start_flush();
        hif.result_ready = 1'b0;
        target = '1;
        do_start(32'd2000);
        drive(rand_hash(), 1'b1);
        drive(rand_hash(), 1'b1);
        idle(3);
        checks++;
        if (hif.result_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b required=1", hif.result_valid); end
        hif.hash_valid = 1'b1;
        hif.hash_in    = rand_hash();
        do_start(32'd3000);
        hif.hash_valid = 1'b0;
        checks += 3;
        if (hif.result_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b required=0", hif.result_valid); end
        if (hash_count !== '0) begin errors++; $display("FAIL flush_count got=%0d required=0", hash_count); end
        if (dropped !== '0) begin errors++; $display("FAIL flush_dropped got=%0d required=0", dropped); end
        idle(3);
        checks++;
        if (hif.result_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got=%b required=0", hif.result_valid); end
        hif.result_ready = 1'b1;
        drive(rand_hash(), 1'b1);
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        hif.result_ready = 1'b1;
        target = {32'h8000_0000, {224{1'b1}}};
        do_start($urandom);
        for (int i = 0; i < 24; i++) drive(rand_hash(), 1'b1);
        wait_drain(40);
        checks += 2;
        if (hash_count !== 32'd24) begin errors++; $display("FAIL b2b_count got=%0d required=24", hash_count); end
        if (dropped !== 16'd0) begin errors++; $display("FAIL b2b_dropped got=%0d required=0", dropped); end
    endtask

    task automatic test_reset_mid();
        hif.result_ready = 1'b0;
        target = '1;
        do_start(32'd4000);
        for (int i = 0; i < 6; i++) drive(rand_hash(), i < DEPTH);
        reset = 1'b1;
        #1;
        checks += 4;
        if (hif.result_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b required=0", hif.result_valid); end
        if (hif.result_nonce !== '0) begin errors++; $display("FAIL mid_nonce got=%h required=0", hif.result_nonce); end
        if (hash_count !== '0) begin errors++; $display("FAIL mid_count got=%0d required=0", hash_count); end
        if (dropped !== '0) begin errors++; $display("FAIL mid_dropped got=%0d required=0", dropped); end
`ifdef KECCAK_HASH_CAPTURE_EN
        checks++;
        if (hif.result_hash !== '0) begin errors++; $display("FAIL mid_hash got=%h required=0", hif.result_hash); end
`endif
        exp_q.delete();
        exp_h_q.delete();
        hif.hash_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_nonce = '0;
        tick();
        hif.result_ready = 1'b1;
        drive(rand_hash(), 1'b1);
        wait_drain(20);
        checks++;
        if (hash_count !== 32'd1) begin errors++; $display("FAIL post_rst_count got=%0d required=1", hash_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compare();
        test_full();
        test_full_push_pop();
        test_wrap();
        test_start_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
